// File: rtl/serial_alu_acc.sv
// serial_alu_acc -- bit-serial add/subtract/accumulate unit with hex display.
//
// Each operation runs one bit per clock through a single full adder, LSB
// first. The result register doubles as the accumulator for modes 10/11.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-high reset
//   start   in   one-cycle operation request, honoured only when idle
//   mode    in   00 R=A+B, 01 R=A-B, 10 R=R+A, 11 R=R-A
//   a, b    in   operands (b unused in modes 10/11)
//   result  out  result / accumulator register R
//   carry   out  carry out of MSB (subtract: 1 = no borrow)
//   ovf     out  two's-complement overflow of the last operation
//   busy    out  high while bits are being processed
//   done    out  one-cycle pulse when result/flags update
//   seg     out  seven-segment codes, 7 bits per nibble of result, LSB digit first
module serial_alu_acc #(
   parameter  int unsigned WIDTH  = 8,
   localparam int unsigned DIGITS = WIDTH / 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [1:0]            mode,
   input  logic [WIDTH-1:0]      a,
   input  logic [WIDTH-1:0]      b,
   output logic [WIDTH-1:0]      result,
   output logic                  carry,
   output logic                  ovf,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int unsigned CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state_q;
   logic [WIDTH-1:0]  x_q, y_q, p_q, result_q;
   logic              c_q, carry_q, ovf_q, busy_q, done_q;
   logic [CW-1:0]     cnt_q;

   // Single-bit full adder shared by every step of the operation.
   logic sum_d, cout_d;
   always_comb begin
      sum_d  = x_q[0] ^ y_q[0] ^ c_q;
      cout_d = (x_q[0] & y_q[0]) | (c_q & (x_q[0] ^ y_q[0]));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         x_q      <= '0;
         y_q      <= '0;
         p_q      <= '0;
         c_q      <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  x_q <= mode[1] ? result_q : a;
                  // Subtraction is X + ~Y + 1: invert Y here, carry-in supplies the +1.
                  y_q <= (mode[1] ? a : b) ^ {WIDTH{mode[0]}};
                  c_q      <= mode[0];
                  p_q      <= '0;
                  cnt_q    <= '0;
                  busy_q   <= 1'b1;
                  state_q  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               x_q   <= x_q >> 1;
               y_q   <= y_q >> 1;
               c_q   <= cout_d;
               p_q   <= {sum_d, p_q[WIDTH-1:1]};
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST) begin
                  // Publish on the final bit so result/flags appear together with done;
                  // c_q is still the carry into the MSB at this point.
                  result_q <= {sum_d, p_q[WIDTH-1:1]};
                  carry_q  <= cout_d;
                  ovf_q    <= c_q ^ cout_d;
                  busy_q   <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Hex to seven-segment, active-high, bit order gfedcba.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   always_comb begin
      seg = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         seg[7*i +: 7] = hex7(result_q[4*i +: 4]);
      end
   end

   assign result = result_q;
   assign carry  = carry_q;
   assign ovf    = ovf_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_serial_alu_acc.sv
// Testbench for serial_alu_acc: directed cases with literal expectations,
// then randomized stimulus checked every cycle against a behavioural model.
module tb_serial_alu_acc;

   localparam int W = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [7:0]  a = '0, b = '0;
   logic [7:0]  result;
   logic        carry, ovf, busy, done;
   logic [13:0] seg;

   logic        start16 = 1'b0;
   logic [1:0]  mode16 = 2'b00;
   logic [15:0] a16 = '0, b16 = '0;
   logic [15:0] result16;
   logic        carry16, ovf16, busy16, done16;
   logic [27:0] seg16;

   always #5 clk = ~clk;

   serial_alu_acc #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .result(result), .carry(carry), .ovf(ovf), .busy(busy), .done(done), .seg(seg)
   );

   serial_alu_acc #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .mode(mode16), .a(a16), .b(b16),
      .result(result16), .carry(carry16), .ovf(ovf16), .busy(busy16), .done(done16), .seg(seg16)
   );

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [6:0] segcode(input int n);
      logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      return tab[n];
   endfunction

   // ---------------- behavioural model (8-bit instance) ----------------
   int m_R = 0, m_C = 0, m_V = 0;   // visible result and flags
   int p_R = 0, p_C = 0, p_V = 0;   // pending operation outcome
   int cyc = 0;                     // 0 idle, 1..W busy, W+1 done cycle

   always @(posedge clk) begin
      if (rst) begin
         m_R = 0; m_C = 0; m_V = 0; cyc = 0;
      end else if (cyc == 0) begin
         if (start) begin
            int ux, uy, sx, sy, sres;
            ux = mode[1] ? m_R : int'(a);
            uy = mode[1] ? int'(a) : int'(b);
            sx = (ux >= 128) ? ux - 256 : ux;
            sy = (uy >= 128) ? uy - 256 : uy;
            if (mode[0]) begin
               p_R = (ux - uy) & 255; p_C = (ux >= uy) ? 1 : 0; sres = sx - sy;
            end else begin
               p_R = (ux + uy) & 255; p_C = (ux + uy > 255) ? 1 : 0; sres = sx + sy;
            end
            p_V = (sres > 127 || sres < -128) ? 1 : 0;
            cyc = 1;
         end
      end else if (cyc == W + 1) begin
         cyc = 0;
      end else begin
         cyc++;
         if (cyc == W + 1) begin
            m_R = p_R; m_C = p_C; m_V = p_V;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [13:0] eseg;
         eseg = {segcode(m_R / 16), segcode(m_R % 16)};
         chk("m_result", result, m_R);
         chk("m_carry",  carry,  m_C);
         chk("m_ovf",    ovf,    m_V);
         chk("m_busy",   busy,   (cyc >= 1 && cyc <= W) ? 1 : 0);
         chk("m_done",   done,   (cyc == W + 1) ? 1 : 0);
         chk("m_seg",    seg,    eseg);
      end
   end

   // ---------------- directed operation helper ----------------
   task automatic op8(input logic [1:0] m, input logic [7:0] av, input logic [7:0] bv,
                      input bit noisy, input bit jitter, output int lat, output int ndone);
      @(negedge clk);
      mode = m; a = av; b = bv; start = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 40) begin
         start = (noisy && (lat == 3 || lat == 8)) ? 1'b1 : 1'b0;
         if (jitter) begin
            a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      start = 1'b0;
      ndone = done ? 1 : 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
   endtask

   initial begin
      int lat, nd;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_en = 1'b1;
      chk("rst_result", result, 8'h00);
      chk("rst_flags",  {carry, ovf, busy, done}, 4'b0000);
      chk("rst_seg",    seg, {7'h3F, 7'h3F});
      rst = 1'b0;

      op8(2'b00, 8'h7F, 8'h01, 0, 0, lat, nd);
      chk("add7F_lat", lat, 9);
      chk("add7F_res", {result, carry, ovf}, {8'h80, 1'b0, 1'b1});
      chk("add7F_seg", seg, {7'h7F, 7'h3F});

      op8(2'b00, 8'hFF, 8'h01, 0, 0, lat, nd);
      chk("addFF_res", {result, carry, ovf}, {8'h00, 1'b1, 1'b0});

      op8(2'b01, 8'h10, 8'h20, 0, 0, lat, nd);
      chk("sub_borrow", {result, carry, ovf}, {8'hF0, 1'b0, 1'b0});
      op8(2'b01, 8'h20, 8'h10, 0, 0, lat, nd);
      chk("sub_noborrow", {result, carry, ovf}, {8'h10, 1'b1, 1'b0});

      @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
      op8(2'b10, 8'h30, 8'hAA, 0, 0, lat, nd);
      chk("acc1", {result, carry, ovf}, {8'h30, 1'b0, 1'b0});
      op8(2'b10, 8'h30, 8'h55, 0, 0, lat, nd);
      chk("acc2", {result, carry, ovf}, {8'h60, 1'b0, 1'b0});
      op8(2'b10, 8'h30, 8'h00, 0, 0, lat, nd);
      chk("acc3", {result, carry, ovf}, {8'h90, 1'b0, 1'b1});
      // 0x90 + ~0x90 + 1: carries into and out of the MSB are both 1, so no overflow.
      op8(2'b11, 8'h90, 8'h00, 0, 0, lat, nd);
      chk("accsub", {result, carry, ovf}, {8'h00, 1'b1, 1'b0});

      op8(2'b00, 8'h12, 8'h34, 1, 0, lat, nd);
      chk("noisy_res", result, 8'h46);
      chk("noisy_ndone", nd, 1);

      op8(2'b00, 8'h05, 8'h06, 0, 1, lat, nd);
      chk("jitter_res", {result, carry, ovf}, {8'h0B, 1'b0, 1'b0});

      // reset in the middle of a shift
      @(negedge clk);
      mode = 2'b00; a = 8'h55; b = 8'h11; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_out", {result, carry, ovf, busy, done}, 12'h000);
      chk("midrst_seg", seg, {7'h3F, 7'h3F});
      rst = 1'b0;
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("midrst_nodone", nd, 0);

      // 16-bit instance
      @(negedge clk);
      mode16 = 2'b00; a16 = 16'hFFFF; b16 = 16'h0001; start16 = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start16 = 1'b0;
      while (!done16 && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("w16_lat", lat, 17);
      chk("w16_res", {result16, carry16, ovf16}, {16'h0000, 1'b1, 1'b0});
      chk("w16_seg", seg16, {4{7'h3F}});

      // randomized traffic, checked by the model every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         a = 8'($urandom); b = 8'($urandom); mode = 2'($urandom);
         start = ($urandom_range(3) == 0);
         rst = ($urandom_range(199) == 0);
      end
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      repeat (W + 4) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
